// File: rtl/instruction_fetch_if.sv
// instruction_fetch_if: instruction memory read handshake plus decode handshake.
interface instruction_fetch_if;
    logic        mem_req, mem_ack, instr_valid, instr_ready;
    logic [31:0] mem_addr, mem_rdata, instr_data, instr_pc;
    modport master (
        output mem_req, mem_addr, instr_valid, instr_data, instr_pc,
        input  mem_ack, mem_rdata, instr_ready
    );
    modport slave (
        input  mem_req, mem_addr, instr_valid, instr_data, instr_pc,
        output mem_ack, mem_rdata, instr_ready
    );
endinterface

// File: rtl/instruction_fetch.sv
// instruction_fetch: single-outstanding instruction fetch FSM with branch redirect
// and a sticky memory-timeout error.
module instruction_fetch #(
    parameter int MAX_WAIT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_value,
    output logic        pc_inclement,
    output logic        pc_load,
    output logic [31:0] pc_load_value,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        fetch_error,
    instruction_fetch_if.master bus
);
    typedef enum logic [2:0] {IDLE, REQ, HOLD, DRAIN, REDIRECT, ERROR} state_t;
    state_t state, next;
    logic [31:0] target, wait_cnt;
    logic timeout;
    assign bus.mem_req = state == REQ || state == DRAIN;
    assign bus.instr_valid = state == HOLD;
    assign fetch_error = state == ERROR;
    assign timeout = bus.mem_req && !bus.mem_ack && wait_cnt == 32'(MAX_WAIT - 1);
    always_comb begin
        next = state;
        pc_inclement = 1'b0;
        pc_load = 1'b0;
        pc_load_value = '0;
        case (state)
            IDLE, REDIRECT: begin
                // IDLE is also the in-reset state, so the pulse must be gated there
                pc_load = redirect_valid && reset;
                pc_load_value = pc_load ? redirect_target : '0;
                next = redirect_valid ? REDIRECT : REQ;
            end
            REQ: begin
                if (timeout) next = ERROR;
                else if (bus.mem_ack && redirect_valid) begin
                    pc_load = 1'b1;
                    pc_load_value = redirect_target;
                    next = REDIRECT;
                end else if (bus.mem_ack) begin
                    pc_inclement = 1'b1;
                    next = HOLD;
                end else if (redirect_valid) next = DRAIN;
            end
            DRAIN: begin
                if (timeout) next = ERROR;
                else if (bus.mem_ack) begin
                    pc_load = 1'b1;
                    pc_load_value = redirect_valid ? redirect_target : target;
                    next = REDIRECT;
                end
            end
            HOLD: begin
                pc_load = redirect_valid;
                pc_load_value = redirect_valid ? redirect_target : '0;
                next = redirect_valid ? REDIRECT : bus.instr_ready ? REQ : HOLD;
            end
            default: ;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            bus.mem_addr <= '0;
            bus.instr_data <= '0;
            bus.instr_pc <= '0;
            target <= '0;
            wait_cnt <= '0;
        end else begin
            state <= next;
            if (next == REQ && state != REQ) bus.mem_addr <= pc_value;
            if (pc_inclement) begin
                bus.instr_data <= bus.mem_rdata;
                bus.instr_pc <= bus.mem_addr;
            end
            if (bus.mem_req && redirect_valid) target <= redirect_target;
            wait_cnt <= (bus.mem_req && !bus.mem_ack) ? wait_cnt + 32'd1 : '0;
        end
    end
endmodule
